if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives a single-outstanding-request instruction-memory port, and loads the IF/ID pipeline register. It is the consumer of the EX-stage redirect interface (`redirect_valid`, `redirect_pc`, `ifid_flush`). It squashes wrong-path fetches, including a fetch still in flight when the redirect arrives. There is no hazard unit, so ID consumes IF/ID every cycle and the stage has no stall input.

---
 rtl/if_fetch_stage_if.sv | 34 +++
 rtl/if_fetch_stage.sv | 110 +++++++++++
 tb/tb_if_fetch_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Signal bundle for the instruction-fetch stage: EX redirect inputs,
// the instruction-memory request/ack port and the IF/ID register outputs.
//
// Memory handshake: the fetch stage raises imem_req with imem_addr and
// holds both steady until the cycle in which imem_ack is high. The
// transfer completes on the clock edge where imem_req && imem_ack,
// and imem_rdata is sampled on that edge. A zero-wait memory may ack
// in the same cycle as the request. The only time imem_req drops without
// an ack is during reset.
interface if_fetch_stage_if;
    // EX-stage redirect
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_flush;
    // instruction memory port
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // IF/ID pipeline register
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;

    modport master (
        input  redirect_valid, redirect_pc, ifid_flush, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_id, pc4_id, valid_id
    );

    modport slave (
        output redirect_valid, redirect_pc, ifid_flush, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_id, pc4_id, valid_id
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC, issues
// one outstanding instruction-memory request at a time, and loads IF/ID.
// A redirect that arrives while a request is still waiting for its ack
// cannot move the address, so the stage parks in SQUASH, lets the old
// request finish, drops its data and then fetches the latest target.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_stage_if.master   bus,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } st_t;

    st_t         st, st_next;
    logic [31:0] pc, pc_next;
    logic [31:0] tgt, tgt_next;
    logic        load_id;
    logic [31:0] pc_seq;

    // Sequential successor is taken from the word-aligned PC, so an
    // unaligned redirect target still steps to the next word boundary
    // and PC+4 wraps modulo 2^32.
    assign pc_seq = {bus.imem_addr[31:2], 2'b00} + 32'd4;

    assign bus.imem_req  = (st == FETCH) || (st == SQUASH);
    assign bus.imem_addr = {pc[31:2], 2'b00};
    assign state         = st;

    // Next-state, next-PC, pending-target and IF/ID-load decisions.
    always_comb begin
        st_next  = st;
        pc_next  = pc;
        tgt_next = tgt;
        load_id  = 1'b0;
        case (st)
            BOOT: begin
                st_next = FETCH;
                if (bus.redirect_valid) pc_next = bus.redirect_pc;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        // fetched word is wrong-path: discard it
                        pc_next = bus.redirect_pc;
                    end else begin
                        pc_next = pc_seq;
                        load_id = 1'b1;
                    end
                end else if (bus.redirect_valid) begin
                    // address must stay put until the ack; remember target
                    tgt_next = bus.redirect_pc;
                    st_next  = SQUASH;
                end
            end
            SQUASH: begin
                if (bus.imem_ack) begin
                    pc_next = bus.redirect_valid ? bus.redirect_pc : tgt;
                    st_next = FETCH;
                end else if (bus.redirect_valid) begin
                    tgt_next = bus.redirect_pc;
                end
            end
            default: begin
                st_next = BOOT;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= BOOT;
        else        st <= st_next;
    end

    // PC and pending redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            tgt <= 32'h0;
        end else begin
            pc  <= pc_next;
            tgt <= tgt_next;
        end
    end

    // IF/ID register: load a good fetch, otherwise insert a bubble that
    // zeroes the instruction and keeps pc4_id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instr_id <= 32'h0;
            bus.pc4_id   <= 32'h0;
            bus.valid_id <= 1'b0;
        end else if (load_id && !bus.ifid_flush) begin
            bus.instr_id <= bus.imem_rdata;
            bus.pc4_id   <= pc_seq;
            bus.valid_id <= 1'b1;
        end else begin
            bus.instr_id <= 32'h0;
            bus.valid_id <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The memory model returns
// imem_addr ^ 32'hDEAD_0000 as the instruction; ack is gated by ack_en
// (ack_en = 1 gives a zero-wait memory).
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [1:0]  S_BOOT = 2'd0, S_FETCH = 2'd1, S_SQUASH = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       ack_en;
    logic [1:0] state;
    int         n_tests;
    int         n_fail;

    if_fetch_stage_if bus();

    if_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_ack   = bus.imem_req & ack_en;
    assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic v, input logic [31:0] target);
        bus.redirect_valid = v;
        bus.redirect_pc    = target;
        bus.ifid_flush     = v;
    endtask

    task automatic check_id(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic v);
        check({tag, ".instr"}, bus.instr_id, instr);
        check({tag, ".pc4"},   bus.pc4_id,   pc4);
        check({tag, ".valid"}, {31'h0, bus.valid_id}, {31'h0, v});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ack_en  = 1'b1;
        redirect(1'b0, 32'h0);

        // reset state
        #12;
        check("rst.req",   {31'h0, bus.imem_req}, 32'h0);
        check("rst.state", {30'h0, state}, {30'h0, S_BOOT});
        check_id("rst", 32'h0, 32'h0, 1'b0);

        // boot: one cycle without request, then sequential fetch
        step();
        rst_n = 1'b1;
        check("boot.req", {31'h0, bus.imem_req}, 32'h0);
        step();
        check("f0.req",  {31'h0, bus.imem_req}, 32'h1);
        check("f0.addr", bus.imem_addr, 32'h0000_0100);
        check("f0.valid", {31'h0, bus.valid_id}, 32'h0);
        step();
        check("f1.addr", bus.imem_addr, 32'h0000_0104);
        check_id("f1", 32'hDEAD_0100, 32'h0000_0104, 1'b1);
        step();
        check("f2.addr", bus.imem_addr, 32'h0000_0108);
        check_id("f2", 32'hDEAD_0104, 32'h0000_0108, 1'b1);
        step();
        check("f3.addr", bus.imem_addr, 32'h0000_010C);
        check_id("f3", 32'hDEAD_0108, 32'h0000_010C, 1'b1);

        // redirect with ack: 0x10C dropped, one bubble, then 0x200
        redirect(1'b1, 32'h0000_0200);
        step();
        redirect(1'b0, 32'h0);
        check("rd.addr", bus.imem_addr, 32'h0000_0200);
        check_id("rd.bub", 32'h0, 32'h0000_010C, 1'b0);
        step();
        check("rd2.addr", bus.imem_addr, 32'h0000_0204);
        check_id("rd2", 32'hDEAD_0200, 32'h0000_0204, 1'b1);

        // ifid_flush alone: bubble, but pc still advances
        bus.ifid_flush = 1'b1;
        step();
        bus.ifid_flush = 1'b0;
        check("fl.addr", bus.imem_addr, 32'h0000_0208);
        check_id("fl.bub", 32'h0, 32'h0000_0204, 1'b0);

        // in-flight redirect: ack withheld, redirect in first wait cycle
        ack_en = 1'b0;
        redirect(1'b1, 32'h0000_0300);
        step();
        redirect(1'b0, 32'h0);
        check("inf.state", {30'h0, state}, {30'h0, S_SQUASH});
        check("inf.addr1", bus.imem_addr, 32'h0000_0208);
        step();
        check("inf.addr2", bus.imem_addr, 32'h0000_0208);
        check("inf.valid", {31'h0, bus.valid_id}, 32'h0);
        ack_en = 1'b1;
        step();
        check("inf.addr3", bus.imem_addr, 32'h0000_0300);
        check("inf.state2", {30'h0, state}, {30'h0, S_FETCH});
        check_id("inf.drop", 32'h0, 32'h0000_0204, 1'b0);
        step();
        check_id("inf.tgt", 32'hDEAD_0300, 32'h0000_0304, 1'b1);

        // double redirect while squashing: latest target wins
        ack_en = 1'b0;
        redirect(1'b1, 32'h0000_0600);
        step();
        redirect(1'b1, 32'h0000_0700);
        step();
        redirect(1'b0, 32'h0);
        check("dbl.addr1", bus.imem_addr, 32'h0000_0304);
        ack_en = 1'b1;
        step();
        check("dbl.addr2", bus.imem_addr, 32'h0000_0700);
        step();
        check_id("dbl", 32'hDEAD_0700, 32'h0000_0704, 1'b1);

        // redirect arriving with the ack in SQUASH overrides stored target
        ack_en = 1'b0;
        redirect(1'b1, 32'h0000_0800);
        step();
        ack_en = 1'b1;
        redirect(1'b1, 32'h0000_0900);
        step();
        redirect(1'b0, 32'h0);
        check("sqa.addr", bus.imem_addr, 32'h0000_0900);
        step();
        check_id("sqa", 32'hDEAD_0900, 32'h0000_0904, 1'b1);

        // wrap and alignment
        redirect(1'b1, 32'hFFFF_FFFE);
        step();
        redirect(1'b0, 32'h0);
        check("wrap.addr1", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap.addr2", bus.imem_addr, 32'h0000_0000);
        check_id("wrap", 32'h2152_FFFC, 32'h0000_0000, 1'b1);

        // mid-fetch reset: request pending, reset asserted mid-cycle
        ack_en = 1'b0;
        step();
        check("mr.req0", {31'h0, bus.imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr.req", {31'h0, bus.imem_req}, 32'h0);
        check("mr.state", {30'h0, state}, {30'h0, S_BOOT});
        check_id("mr", 32'h0, 32'h0, 1'b0);
        step();
        rst_n = 1'b1;
        check("mr.boot", {31'h0, bus.imem_req}, 32'h0);
        step();
        check("mr.addr", bus.imem_addr, RST_PC);
        ack_en = 1'b1;
        step();
        check_id("mr.f0", 32'hDEAD_0100, 32'h0000_0104, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
